// File: rtl/writeback_regfile_unit.sv
// Writeback stage: selects MEM/WB result, writes the 32x32 register file,
// serves decode reads with same-cycle bypass, and keeps debug/display state.
module writeback_regfile_unit #(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter logic [4:0]  JAL_REG     = 5'd31
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   MemtoRegW,
  input  logic                   RegWriteW,
  input  logic [31:0]            MemReadDataW,
  input  logic [31:0]            ALUResultW,
  input  logic [4:0]             WriteRegW,
  input  logic [31:0]            PCPlus4W,
  input  logic                   jalW,
  input  logic                   DisplayW,
  input  logic [31:0]            instructionW,
  input  logic [4:0]             ReadReg1,
  input  logic [4:0]             ReadReg2,
  output logic [31:0]            ReadData1,
  output logic [31:0]            ReadData2,
  output logic [31:0]            WriteDataW,
  output logic [4:0]             WriteDestW,
  output logic [31:0]            DisplayValue,
  output logic [COUNT_WIDTH-1:0] RetireCount,
  output logic [31:0]            LastRetired
);

  logic [31:0]            regs_q [32];
  logic [31:0]            regs_d [32];
  logic [31:0]            disp_q, disp_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]            last_q, last_d;
  logic                   we_eff;
  logic                   fwd_ok;

  always_comb begin
    WriteDataW = jalW ? PCPlus4W
                      : (MemtoRegW ? MemReadDataW : ALUResultW);
    WriteDestW = jalW ? JAL_REG : WriteRegW;
    fwd_ok     = RegWriteW && !Reset;
    we_eff     = fwd_ok && (WriteDestW != 5'd0);
  end

  always_comb begin
    regs_d = regs_q;
    if (we_eff) regs_d[WriteDestW] = WriteDataW;
  end

  // Bypass is gated on RegWriteW first so X fields never reach the reads
  always_comb begin
    ReadData1 = regs_q[ReadReg1];
    if (ReadReg1 == 5'd0)
      ReadData1 = '0;
    else if (fwd_ok && (WriteDestW == ReadReg1))
      ReadData1 = WriteDataW;
  end

  always_comb begin
    ReadData2 = regs_q[ReadReg2];
    if (ReadReg2 == 5'd0)
      ReadData2 = '0;
    else if (fwd_ok && (WriteDestW == ReadReg2))
      ReadData2 = WriteDataW;
  end

  always_comb begin
    disp_d = disp_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (DisplayW) disp_d = WriteDataW;
    if (instructionW != 32'd0) begin
      last_d = instructionW;
      if (cnt_q != '1) cnt_d = cnt_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      disp_q <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      regs_q <= regs_d;
      disp_q <= disp_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign DisplayValue = disp_q;
  assign RetireCount  = cnt_q;
  assign LastRetired  = last_q;

endmodule

// File: tb/tb_writeback_regfile_unit.sv
// Bench for writeback_regfile_unit: directed vector table plus
// hand-written saturation and mid-stream reset sequences.
module tb_writeback_regfile_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MemtoRegW, RegWriteW, jalW, DisplayW;
  logic [31:0] MemReadDataW, ALUResultW, PCPlus4W, instructionW;
  logic [4:0]  WriteRegW, ReadReg1, ReadReg2;

  logic [31:0] rd1, rd2, wd, disp, last;
  logic [4:0]  wdest;
  logic [31:0] cnt;

  logic [31:0] s_rd1, s_rd2, s_wd, s_disp, s_last;
  logic [4:0]  s_wdest;
  logic [3:0]  s_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  writeback_regfile_unit u_dut (
    .Clk(Clk), .Reset(Reset),
    .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW),
    .MemReadDataW(MemReadDataW), .ALUResultW(ALUResultW),
    .WriteRegW(WriteRegW), .PCPlus4W(PCPlus4W),
    .jalW(jalW), .DisplayW(DisplayW),
    .instructionW(instructionW),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1), .ReadData2(rd2),
    .WriteDataW(wd), .WriteDestW(wdest),
    .DisplayValue(disp), .RetireCount(cnt),
    .LastRetired(last)
  );

  writeback_regfile_unit #(.COUNT_WIDTH(4)) u_sat (
    .Clk(Clk), .Reset(Reset),
    .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW),
    .MemReadDataW(MemReadDataW), .ALUResultW(ALUResultW),
    .WriteRegW(WriteRegW), .PCPlus4W(PCPlus4W),
    .jalW(jalW), .DisplayW(DisplayW),
    .instructionW(instructionW),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(s_rd1), .ReadData2(s_rd2),
    .WriteDataW(s_wd), .WriteDestW(s_wdest),
    .DisplayValue(s_disp), .RetireCount(s_cnt),
    .LastRetired(s_last)
  );

  typedef struct {
    logic        rst;
    logic        m2r;
    logic        rw;
    logic [31:0] mdata;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic [31:0] pc4;
    logic        jal;
    logic        dsp;
    logic [31:0] instr;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_wd;
    logic [4:0]  e_wdest;
    logic [31:0] e_disp;
    logic [31:0] e_cnt;
    logic [31:0] e_last;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    Reset = 1'b0; MemtoRegW = 1'b0; RegWriteW = 1'b0;
    jalW = 1'b0; DisplayW = 1'b0;
    MemReadDataW = '0; ALUResultW = '0; PCPlus4W = '0;
    instructionW = '0; WriteRegW = '0;
    ReadReg1 = '0; ReadReg2 = '0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{rst:1, m2r:0, rw:1, mdata:0, alu:32'hAAAA, wreg:5,
                 pc4:0, jal:0, dsp:1, instr:32'h1111, rr1:5, rr2:31,
                 e_rd1:0, e_rd2:0, e_wd:32'hAAAA, e_wdest:5,
                 e_disp:0, e_cnt:0, e_last:0};
    vecs[1]  = '{rst:0, m2r:0, rw:1, mdata:0, alu:32'h1234, wreg:8,
                 pc4:0, jal:0, dsp:0, instr:0, rr1:8, rr2:5,
                 e_rd1:32'h1234, e_rd2:0, e_wd:32'h1234, e_wdest:8,
                 e_disp:0, e_cnt:0, e_last:0};
    vecs[2]  = '{rst:0, m2r:0, rw:0, mdata:0, alu:32'h9999, wreg:8,
                 pc4:0, jal:0, dsp:0, instr:0, rr1:8, rr2:8,
                 e_rd1:32'h1234, e_rd2:32'h1234, e_wd:32'h9999,
                 e_wdest:8, e_disp:0, e_cnt:0, e_last:0};
    vecs[3]  = '{rst:0, m2r:1, rw:1, mdata:32'hDEADBEEF, alu:32'h5555,
                 wreg:9, pc4:0, jal:0, dsp:0, instr:0, rr1:9, rr2:8,
                 e_rd1:32'hDEADBEEF, e_rd2:32'h1234,
                 e_wd:32'hDEADBEEF, e_wdest:9,
                 e_disp:0, e_cnt:0, e_last:0};
    vecs[4]  = '{rst:0, m2r:1, rw:1, mdata:32'hDEADBEEF, alu:32'h77,
                 wreg:4, pc4:32'h40, jal:1, dsp:0, instr:0,
                 rr1:31, rr2:4, e_rd1:32'h40, e_rd2:0, e_wd:32'h40,
                 e_wdest:31, e_disp:0, e_cnt:0, e_last:0};
    vecs[5]  = '{rst:0, m2r:0, rw:0, mdata:0, alu:0, wreg:0,
                 pc4:0, jal:0, dsp:0, instr:0, rr1:31, rr2:9,
                 e_rd1:32'h40, e_rd2:32'hDEADBEEF, e_wd:0, e_wdest:0,
                 e_disp:0, e_cnt:0, e_last:0};
    vecs[6]  = '{rst:0, m2r:0, rw:1, mdata:0, alu:32'hFFFFFFFF, wreg:0,
                 pc4:0, jal:0, dsp:0, instr:0, rr1:4, rr2:0,
                 e_rd1:0, e_rd2:0, e_wd:32'hFFFFFFFF, e_wdest:0,
                 e_disp:0, e_cnt:0, e_last:0};
    vecs[7]  = '{rst:0, m2r:0, rw:0, mdata:0, alu:0, wreg:0,
                 pc4:0, jal:0, dsp:0, instr:0, rr1:0, rr2:0,
                 e_rd1:0, e_rd2:0, e_wd:0, e_wdest:0,
                 e_disp:0, e_cnt:0, e_last:0};
    vecs[8]  = '{rst:0, m2r:0, rw:0, mdata:0, alu:0, wreg:0,
                 pc4:0, jal:0, dsp:0, instr:32'h20080005, rr1:8, rr2:9,
                 e_rd1:32'h1234, e_rd2:32'hDEADBEEF, e_wd:0, e_wdest:0,
                 e_disp:0, e_cnt:0, e_last:0};
    vecs[9]  = '{rst:0, m2r:0, rw:0, mdata:0, alu:0, wreg:0,
                 pc4:0, jal:0, dsp:0, instr:0, rr1:0, rr2:0,
                 e_rd1:0, e_rd2:0, e_wd:0, e_wdest:0,
                 e_disp:0, e_cnt:1, e_last:32'h20080005};
    vecs[10] = '{rst:0, m2r:0, rw:0, mdata:0, alu:32'h77, wreg:0,
                 pc4:0, jal:0, dsp:1, instr:32'h8C090000, rr1:0, rr2:0,
                 e_rd1:0, e_rd2:0, e_wd:32'h77, e_wdest:0,
                 e_disp:0, e_cnt:1, e_last:32'h20080005};
    vecs[11] = '{rst:0, m2r:0, rw:0, mdata:0, alu:0, wreg:0,
                 pc4:0, jal:0, dsp:0, instr:0, rr1:31, rr2:8,
                 e_rd1:32'h40, e_rd2:32'h1234, e_wd:0, e_wdest:0,
                 e_disp:32'h77, e_cnt:2, e_last:32'h8C090000};
    vecs[12] = '{rst:0, m2r:1, rw:0, mdata:32'hCAFE0001, alu:0, wreg:10,
                 pc4:0, jal:0, dsp:1, instr:0, rr1:10, rr2:0,
                 e_rd1:0, e_rd2:0, e_wd:32'hCAFE0001, e_wdest:10,
                 e_disp:32'h77, e_cnt:2, e_last:32'h8C090000};
    vecs[13] = '{rst:0, m2r:0, rw:1, mdata:0, alu:32'hABCD, wreg:10,
                 pc4:0, jal:0, dsp:1, instr:32'h13, rr1:10, rr2:10,
                 e_rd1:32'hABCD, e_rd2:32'hABCD, e_wd:32'hABCD,
                 e_wdest:10, e_disp:32'hCAFE0001, e_cnt:2,
                 e_last:32'h8C090000};
    vecs[14] = '{rst:0, m2r:0, rw:0, mdata:0, alu:0, wreg:0,
                 pc4:0, jal:0, dsp:0, instr:0, rr1:10, rr2:31,
                 e_rd1:32'hABCD, e_rd2:32'h40, e_wd:0, e_wdest:0,
                 e_disp:32'hABCD, e_cnt:3, e_last:32'h13};

    idle();
    Reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      Reset        = vecs[i].rst;
      MemtoRegW    = vecs[i].m2r;
      RegWriteW    = vecs[i].rw;
      MemReadDataW = vecs[i].mdata;
      ALUResultW   = vecs[i].alu;
      WriteRegW    = vecs[i].wreg;
      PCPlus4W     = vecs[i].pc4;
      jalW         = vecs[i].jal;
      DisplayW     = vecs[i].dsp;
      instructionW = vecs[i].instr;
      ReadReg1     = vecs[i].rr1;
      ReadReg2     = vecs[i].rr2;
      @(negedge Clk);
      chk($sformatf("v%0d rd1", i), rd1, vecs[i].e_rd1);
      chk($sformatf("v%0d rd2", i), rd2, vecs[i].e_rd2);
      chk($sformatf("v%0d wd", i), wd, vecs[i].e_wd);
      chk($sformatf("v%0d wdest", i), {27'd0, wdest},
          {27'd0, vecs[i].e_wdest});
      chk($sformatf("v%0d disp", i), disp, vecs[i].e_disp);
      chk($sformatf("v%0d cnt", i), cnt, vecs[i].e_cnt);
      chk($sformatf("v%0d last", i), last, vecs[i].e_last);
      chk($sformatf("v%0d s_rd1", i), s_rd1, vecs[i].e_rd1);
      chk($sformatf("v%0d s_rd2", i), s_rd2, vecs[i].e_rd2);
      chk($sformatf("v%0d s_wd", i), s_wd, vecs[i].e_wd);
      chk($sformatf("v%0d s_wdest", i), {27'd0, s_wdest},
          {27'd0, vecs[i].e_wdest});
      chk($sformatf("v%0d s_disp", i), s_disp, vecs[i].e_disp);
      chk($sformatf("v%0d s_last", i), s_last, vecs[i].e_last);
      chk($sformatf("v%0d s_cnt", i), {28'd0, s_cnt},
          vecs[i].e_cnt);
      tick();
    end

    // Saturation of the narrow counter
    idle();
    Reset = 1'b1;
    tick();
    idle();
    #1;
    chk("sat cnt after reset", {28'd0, s_cnt}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      instructionW = 32'h100 + i;
      tick();
      if (i == 14) begin
        chk("sat cnt at 15", {28'd0, s_cnt}, 32'd15);
        chk("main cnt at 15", cnt, 32'd15);
      end
    end
    idle();
    #1;
    chk("sat cnt held", {28'd0, s_cnt}, 32'd15);
    chk("main cnt 17", cnt, 32'd17);
    chk("last after 17", last, 32'h110);
    chk("sat last after 17", s_last, 32'h110);

    // Mid-stream reset drops the in-flight write and count
    RegWriteW = 1'b1; WriteRegW = 5'd3; ALUResultW = 32'h11;
    tick();
    idle();
    ReadReg1 = 5'd3;
    #1;
    chk("reg3 written", rd1, 32'h11);
    Reset = 1'b1; RegWriteW = 1'b1; WriteRegW = 5'd3;
    ALUResultW = 32'h33; instructionW = 32'h55; DisplayW = 1'b1;
    ReadReg1 = 5'd3;
    @(negedge Clk);
    chk("no bypass in reset", rd1, 32'h11);
    tick();
    idle();
    ReadReg1 = 5'd3; ReadReg2 = 5'd31;
    #1;
    chk("reg3 after reset", rd1, 32'd0);
    chk("reg31 after reset", rd2, 32'd0);
    chk("cnt after reset", cnt, 32'd0);
    chk("sat cnt after reset2", {28'd0, s_cnt}, 32'd0);
    chk("last after reset", last, 32'd0);
    chk("disp after reset", disp, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
